// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: grants one of N requesters, registered one-hot grant plus binary index.
// Latency: request sampled at edge k is reflected in gnt after edge k (1 cycle).
// Backpressure: owner keeps the grant while it requests, bounded by MAX_HOLD; en=0 drops the grant.
module rr_req_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // Hold counter only needs to reach MAX_HOLD-1.
    localparam int HW          = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LAST_I);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_n;
    logic [N-1:0]     gnt_n;
    logic [IDX_W-1:0] idx_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [HW-1:0]    hold_cnt, hold_n;

    logic             found_ptr, found_after;
    logic [IDX_W-1:0] pick_ptr, pick_after;
    logic [IDX_W-1:0] ptr_after;
    logic             timeout;

    // First set request searched cyclically from start; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r, input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] jj;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDX_W'(j);
            if (!found && r[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
        return {found, idx};
    endfunction

    // Candidate selections: from the current pointer and from just past the current owner.
    always_comb begin
        ptr_after                 = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        {found_ptr, pick_ptr}     = rr_pick(req, ptr);
        {found_after, pick_after} = rr_pick(req, ptr_after);
        timeout                   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    end

    // Next-state and next-grant decision.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                gnt_n = '0;
                idx_n = '0;
                if (en && (|req)) begin
                    state_n        = GRANT;
                    gnt_n[pick_ptr] = 1'b1;
                    idx_n          = pick_ptr;
                    hold_n         = '0;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    idx_n   = '0;
                    hold_n  = '0;
                end else if (!req[gnt_idx] || timeout) begin
                    // Release or timeout: move priority past the owner and re-arbitrate
                    // in the same edge, so there is no idle bubble.
                    ptr_n  = ptr_after;
                    hold_n = '0;
                    if (found_after) begin
                        gnt_n             = '0;
                        gnt_n[pick_after] = 1'b1;
                        idx_n             = pick_after;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        idx_n   = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_idx  <= idx_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Testbench for rr_req_arbiter: directed literal checks plus randomized traffic against a reference model.
// Latency: model and DUT both advance on each rising edge; outputs sampled on the falling edge.
// Backpressure: stimulus drives en/req/rst freely, including mid-grant resets and enable drops.
module tb_rr_req_arbiter;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the resource, where the search starts, cycles owned so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit armed   = 1'b0;

    rr_req_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Model update on every rising edge, from the inputs that were stable before it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1;
                m_ptr   = 0;
                m_held  = 0;
            end else if (m_owner < 0) begin
                if (en && req != '0) begin
                    m_owner = search(req, m_ptr);
                    m_held  = 1;
                end
            end else if (!en) begin
                m_owner = -1;
            end else if (!req[m_owner] || m_held == MAX_HOLD) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = search(req, m_ptr);
                m_held  = 1;
            end else begin
                m_held++;
            end
            armed = 1'b1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("model_gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
                chk("model_idx", int'(gnt_idx), (m_owner < 0) ? 0 : m_owner);
                chk("model_valid", int'(gnt_valid), (m_owner < 0) ? 0 : 1);
                chk("onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset holds everything at zero even with all requests high.
        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_idx", int'(gnt_idx), 0);
            chk("rst_valid", int'(gnt_valid), 0);
        end
        rst = 1'b0;
        tick();
        chk("first_after_rst_idx", int'(gnt_idx), 0);
        chk("first_after_rst_gnt", int'(gnt), 8'h01);

        // Single requester grant and release.
        do_reset();
        req = 8'h10;
        tick();
        chk("single_gnt", int'(gnt), 8'h10);
        chk("single_idx", int'(gnt_idx), 4);
        chk("single_valid", int'(gnt_valid), 1);
        req = 8'h00;
        tick();
        chk("single_drop_gnt", int'(gnt), 0);

        // Rotation with every requester active: 4 cycles each, no gaps, wraps to 0.
        do_reset();
        req = 8'hFF;
        for (int t = 0; t <= 32; t++) begin
            tick();
            chk("rotate_idx", int'(gnt_idx), (t / 4) % 8);
            chk("rotate_valid", int'(gnt_valid), 1);
        end

        // Handoff without a bubble, then pointer wrap from 7 back to 0.
        do_reset();
        req = 8'h81;
        tick();
        chk("handoff_first_idx", int'(gnt_idx), 0);
        req = 8'h80;
        tick();
        chk("handoff_gnt", int'(gnt), 8'h80);
        req = 8'h00;
        tick();
        chk("handoff_release_gnt", int'(gnt), 0);
        req = 8'h81;
        tick();
        chk("wrap_idx", int'(gnt_idx), 0);
        chk("wrap_gnt", int'(gnt), 8'h01);

        // Lone owner keeps being re-granted across timeouts.
        do_reset();
        req = 8'h08;
        for (int t = 0; t < 12; t++) begin
            tick();
            chk("lone_gnt", int'(gnt), 8'h08);
        end

        // Enable drop and restore, then reset mid-grant.
        do_reset();
        req = 8'h18;
        tick();
        chk("en_first_idx", int'(gnt_idx), 3);
        en = 1'b0;
        tick();
        chk("en_off_gnt", int'(gnt), 0);
        en = 1'b1;
        tick();
        chk("en_on_idx", int'(gnt_idx), 3);
        chk("en_on_gnt", int'(gnt), 8'h08);
        rst = 1'b1;
        tick();
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_idx", int'(gnt_idx), 0);
        chk("midrst_valid", int'(gnt_valid), 0);
        rst = 1'b0;

        // Randomized traffic: slowly evolving request vector, occasional enable drops and resets.
        for (int c = 0; c < 3000; c++) begin
            int r;
            int b;
            r   = int'($urandom_range(0, 99));
            rst = (r < 2);
            en  = ($urandom_range(0, 19) != 0);
            if (r < 30) begin
                b      = int'($urandom_range(0, N - 1));
                req[b] = ~req[b];
            end else if (r < 35) begin
                req = N'($urandom);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
